boot_loader: RTL

- Byte-serial program/data loader that sits directly upstream of the single-cycle MIPS core.
- Receives a framed byte stream and writes its payload into the core's instruction memory or data memory.
- Holds the core in reset while loading and releases it on a GO command.
- Replaces the bench-side memory preload and hand-set PC reset with a synthesizable boot path.

---
 rtl/boot_loader_pkg.sv | 26 ++
 rtl/boot_loader_if.sv | 25 ++
 rtl/boot_loader_frame_counter.sv | 41 ++++
 rtl/boot_loader.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared command bytes and FSM state enum for the boot loader
// Contents: CMD_I/CMD_D/CMD_G/CMD_H command bytes, boot_state_e frame FSM states,
//           is_load_cmd() helper recognising the two memory-load commands.
package mips_boot_pkg;

    localparam logic [7:0] CMD_I = 8'h49;
    localparam logic [7:0] CMD_D = 8'h44;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] CMD_H = 8'h48;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        CNT_HI,
        CNT_LO,
        PAYLOAD,
        CHKSUM,
        RUN
    } boot_state_e;

    function automatic logic is_load_cmd(input logic [7:0] b);
        return (b == CMD_I) || (b == CMD_D);
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// rtl/boot_loader_if.sv - byte stream in, memory byte-write bus out
// Signals: rx_data/rx_valid/rx_ready inbound byte handshake;
//          im_we/dm_we/mem_addr/mem_wdata byte write towards instruction/data memory.
// Modports: master = stream source and memory side, slave = the loader.
interface boot_loader_if #(
    parameter int ADDR_W = 16
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_we;
    logic              dm_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, im_we, dm_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, im_we, dm_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/boot_loader_frame_counter.sv
// rtl/boot_loader_frame_counter.sv - frame address, remaining count and payload checksum
// Ports: clk, rst_n (async active-low); din = accepted byte;
//        ld_hi latches a high byte, ld_addr/ld_cnt load {hi,din} into address/count,
//        step advances one payload byte; addr/cnt/sum/hold expose the registers.
module boot_frame_counter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        din,
    input  logic              ld_hi,
    input  logic              ld_addr,
    input  logic              ld_cnt,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       cnt,
    output logic [7:0]        sum,
    output logic [7:0]        hold
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            cnt  <= '0;
            sum  <= '0;
            hold <= '0;
        end else begin
            // ADDR_HI and CNT_HI share one holding byte; the low byte completes the field.
            if (ld_hi)   hold <= din;
            if (ld_addr) addr <= ADDR_W'({hold, din});
            if (ld_cnt) begin
                cnt <= {hold, din};
                sum <= '0;
            end
            if (step) begin
                addr <= addr + ADDR_W'(1);   // wraps modulo 2^ADDR_W
                cnt  <= cnt - 16'd1;
                sum  <= sum + din;
            end
        end
    end
endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - framed byte-stream loader for instruction/data memory with core reset control
// Ports: clk, rst_n (async active-low); bus (boot_loader_if.slave) byte stream in and
//        byte writes out; cpu_rst_n core reset (low while loading); busy = frame in progress;
//        err = sticky error, cleared by rst_n or the start of a load frame.
module boot_loader
    import mips_boot_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    boot_loader_if.slave  bus,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic          err
);
    boot_state_e       state, state_n;
    logic              rdy_q;
    logic              im_we_q, dm_we_q, im_we_n, dm_we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [7:0]        wdata_q, wdata_n;
    logic              err_q, err_n;
    logic              tgt_dm, tgt_dm_n;
    logic              ld_hi, ld_addr, ld_cnt, step;
    logic [ADDR_W-1:0] ctr_addr;
    logic [15:0]       ctr_cnt;
    logic [7:0]        ctr_sum, ctr_hold;
    logic              xfer;

    assign xfer = bus.rx_valid && rdy_q;

    boot_frame_counter #(.ADDR_W(ADDR_W)) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (bus.rx_data),
        .ld_hi   (ld_hi),
        .ld_addr (ld_addr),
        .ld_cnt  (ld_cnt),
        .step    (step),
        .addr    (ctr_addr),
        .cnt     (ctr_cnt),
        .sum     (ctr_sum),
        .hold    (ctr_hold)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdy_q   <= 1'b0;
            im_we_q <= 1'b0;
            dm_we_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            tgt_dm  <= 1'b0;
        end else begin
            state   <= state_n;
            rdy_q   <= 1'b1;
            im_we_q <= im_we_n;
            dm_we_q <= dm_we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            err_q   <= err_n;
            tgt_dm  <= tgt_dm_n;
        end
    end

    always_comb begin
        state_n  = state;
        im_we_n  = 1'b0;
        dm_we_n  = 1'b0;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        err_n    = err_q;
        tgt_dm_n = tgt_dm;
        ld_hi    = 1'b0;
        ld_addr  = 1'b0;
        ld_cnt   = 1'b0;
        step     = 1'b0;
        if (xfer) begin
            case (state)
                IDLE: begin
                    if (is_load_cmd(bus.rx_data)) begin
                        tgt_dm_n = (bus.rx_data == CMD_D);
                        err_n    = 1'b0;
                        state_n  = ADDR_HI;
                    end else if (bus.rx_data == CMD_G) begin
                        state_n = RUN;
                    end else if (bus.rx_data != CMD_H) begin
                        err_n = 1'b1;
                    end
                end
                ADDR_HI: begin
                    ld_hi   = 1'b1;
                    state_n = ADDR_LO;
                end
                ADDR_LO: begin
                    ld_addr = 1'b1;
                    state_n = CNT_HI;
                end
                CNT_HI: begin
                    ld_hi   = 1'b1;
                    state_n = CNT_LO;
                end
                CNT_LO: begin
                    ld_cnt  = 1'b1;
                    state_n = ({ctr_hold, bus.rx_data} == 16'd0) ? CHKSUM : PAYLOAD;
                end
                PAYLOAD: begin
                    // Write uses the pre-increment address; counter steps on the same edge.
                    step    = 1'b1;
                    im_we_n = !tgt_dm;
                    dm_we_n = tgt_dm;
                    addr_n  = ctr_addr;
                    wdata_n = bus.rx_data;
                    if (ctr_cnt == 16'd1) state_n = CHKSUM;
                end
                CHKSUM: begin
                    if (bus.rx_data != ctr_sum) err_n = 1'b1;
                    state_n = IDLE;
                end
                RUN: begin
                    if (bus.rx_data == CMD_H) state_n = IDLE;
                    else                      err_n   = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Core only runs in RUN, which never issues writes, so strobes and a running core cannot overlap.
    assign cpu_rst_n     = (state == RUN);
    assign busy          = (state != IDLE) && (state != RUN);
    assign err           = err_q;
    assign bus.rx_ready  = rdy_q;
    assign bus.im_we     = im_we_q;
    assign bus.dm_we     = dm_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule
